// File: rtl/turn_sig_pkg.sv
// Shared types and default constants for the turn-signal input conditioner.
// The debug struct bundles arbitration state and per-channel debounce status.
package turn_sig_pkg;

  typedef enum logic [1:0] {
    TS_IDLE   = 2'd0,
    TS_LEFT   = 2'd1,
    TS_RIGHT  = 2'd2,
    TS_HAZARD = 2'd3
  } ts_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_MIN_ON_CYCLES   = 3;

  // Channel bit order in the vectors below is {left, right, hazard}.
  typedef struct packed {
    ts_state_e  state;
    logic [2:0] db;
    logic [2:0] db_rise;
  } ts_dbg_t;

  function automatic logic [2:0] ts_decode(input ts_state_e s);
    ts_decode = {(s == TS_LEFT)  || (s == TS_HAZARD),
                 (s == TS_RIGHT) || (s == TS_HAZARD),
                 (s == TS_HAZARD)};
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Synchroniser chain followed by a consecutive-sample debounce counter.
// o_db_rise pulses for one cycle on the edge where o_db flips 0->1.
module switch_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_db,
  output logic o_db_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_db;
  logic                   r_db_rise;
  logic                   w_sync;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign o_db      = r_db;
  assign o_db_rise = r_db_rise;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_db      <= 1'b0;
      r_db_rise <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_db_rise <= 1'b0;
      if (w_sync != r_db) begin
        // The DEBOUNCE_CYCLES-th differing sample flips the level on this edge.
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_db      <= ~r_db;
          r_db_rise <= ~r_db;
          r_cnt     <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/turn_signal_conditioner.sv
// Debounces left/right/hazard switches and arbitrates them into request levels.
// Define TURN_SIG_LATCH_EN for tap/toggle mode; default is level mode.
import turn_sig_pkg::*;

module turn_signal_conditioner #(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_ON_CYCLES   = DEF_MIN_ON_CYCLES
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    left_raw,
  input  logic    right_raw,
  input  logic    hazard_raw,
  output logic    left,
  output logic    right,
  output logic    hazard_active,
  output ts_dbg_t dbg_state
);

  localparam int MW = $clog2(MIN_ON_CYCLES + 1);

  logic      w_left_db, w_right_db, w_hazard_db;
  logic      w_left_rise, w_right_rise, w_hazard_rise;
  ts_state_e r_state, w_next;
  logic [MW-1:0] r_min_cnt;
  logic      r_left, r_right, r_hazard;
  logic      w_min_done;

  switch_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .i_clk(clk), .i_reset(reset), .i_raw(left_raw), .o_db(w_left_db), .o_db_rise(w_left_rise)
  );
  switch_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .i_clk(clk), .i_reset(reset), .i_raw(right_raw), .o_db(w_right_db), .o_db_rise(w_right_rise)
  );
  switch_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hazard (
    .i_clk(clk), .i_reset(reset), .i_raw(hazard_raw), .o_db(w_hazard_db), .o_db_rise(w_hazard_rise)
  );

  assign w_min_done = (r_min_cnt == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      TS_IDLE: begin
        if (w_hazard_db || (w_left_db && w_right_db)) w_next = TS_HAZARD;
`ifdef TURN_SIG_LATCH_EN
        else if (w_left_rise)  w_next = TS_LEFT;
        else if (w_right_rise) w_next = TS_RIGHT;
`else
        else if (w_left_db)    w_next = TS_LEFT;
        else if (w_right_db)   w_next = TS_RIGHT;
`endif
      end
      TS_LEFT: begin
        if (w_hazard_db) w_next = TS_HAZARD;
`ifdef TURN_SIG_LATCH_EN
        else if (w_right_rise || (w_left_rise && w_min_done)) w_next = TS_IDLE;
`else
        else if (!w_left_db && w_min_done) w_next = TS_IDLE;
`endif
      end
      TS_RIGHT: begin
        if (w_hazard_db) w_next = TS_HAZARD;
`ifdef TURN_SIG_LATCH_EN
        else if (w_left_rise || (w_right_rise && w_min_done)) w_next = TS_IDLE;
`else
        else if (!w_right_db && w_min_done) w_next = TS_IDLE;
`endif
      end
      TS_HAZARD: begin
        if (!w_hazard_db && !(w_left_db && w_right_db)) w_next = TS_IDLE;
      end
      default: w_next = TS_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= TS_IDLE;
      r_min_cnt <= '0;
      r_left    <= 1'b0;
      r_right   <= 1'b0;
      r_hazard  <= 1'b0;
    end else begin
      r_state <= w_next;
      {r_left, r_right, r_hazard} <= ts_decode(w_next);
      if ((r_state == TS_IDLE) && ((w_next == TS_LEFT) || (w_next == TS_RIGHT)))
        r_min_cnt <= MW'(MIN_ON_CYCLES - 1);
      else if (!w_min_done)
        r_min_cnt <= r_min_cnt - 1'b1;
    end
  end

  assign left          = r_left;
  assign right         = r_right;
  assign hazard_active = r_hazard;

  assign dbg_state.state   = r_state;
  assign dbg_state.db      = {w_left_db, w_right_db, w_hazard_db};
  assign dbg_state.db_rise = {w_left_rise, w_right_rise, w_hazard_rise};

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Directed bench for turn_signal_conditioner: pulse table plus hand-written
// sequences for reset, arbitration order, hazard override and tap mode.
import turn_sig_pkg::*;

module tb_turn_signal_conditioner;

  logic    clk = 1'b0;
  logic    reset;
  logic    left_raw, right_raw, hazard_raw;
  logic    left, right, hazard_active;
  ts_dbg_t dbg_state;

  int checks   = 0;
  int failures = 0;

  turn_signal_conditioner dut (
    .clk(clk), .reset(reset),
    .left_raw(left_raw), .right_raw(right_raw), .hazard_raw(hazard_raw),
    .left(left), .right(right), .hazard_active(hazard_active),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // One raw pulse on a single channel; outputs equal exp_out on edges first..last.
  typedef struct {
    logic [2:0] chan;
    int         len;
    int         first;
    int         last;
    logic [2:0] exp_out;
  } scen_t;

  scen_t scen[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check3(input string name, input int step, input logic [2:0] exp);
    logic [2:0] act;
    act = {left, right, hazard_active};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d: {left,right,hazard}=%b expected %b", name, step, act, exp);
    end
  endtask

  task automatic reset_dut();
    reset      = 1'b1;
    left_raw   = 1'b0;
    right_raw  = 1'b0;
    hazard_raw = 1'b0;
    tick();
    tick();
    #3 reset = 1'b0;
  endtask

  initial begin
    scen[0] = '{3'b100, 3, 99, 0,  3'b100};
    scen[1] = '{3'b100, 4, 7,  10, 3'b100};
    scen[2] = '{3'b010, 5, 7,  11, 3'b010};
    scen[3] = '{3'b100, 6, 7,  12, 3'b100};
    scen[4] = '{3'b001, 4, 7,  10, 3'b111};
    scen[5] = '{3'b010, 3, 99, 0,  3'b010};

    // Reset held 20 ns with every switch on; hazard appears on the 7th edge.
    reset = 1'b1; left_raw = 1'b1; right_raw = 1'b1; hazard_raw = 1'b1;
    #1 check3("reset_hold_t1", 0, 3'b000);
    #18 check3("reset_hold_t19", 0, 3'b000);
    #1 reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) check3("post_reset_edge6", e, 3'b000);
      if (e == 7) check3("post_reset_edge7", e, 3'b111);
    end
    left_raw = 1'b0; right_raw = 1'b0; hazard_raw = 1'b0;
    repeat (12) tick();
    check3("all_released", 0, 3'b000);

`ifndef TURN_SIG_LATCH_EN
    // Pulse table: short pulses are filtered, longer ones stretch to their length.
    for (int s = 0; s < 6; s++) begin
      reset_dut();
      for (int k = 1; k <= 16; k++) begin
        {left_raw, right_raw, hazard_raw} = (k <= scen[s].len) ? scen[s].chan : 3'b000;
        tick();
        check3($sformatf("pulse_s%0d", s), k,
               (k >= scen[s].first && k <= scen[s].last) ? scen[s].exp_out : 3'b000);
      end
    end

    // First-come wins; right follows after one idle cycle.
    reset_dut();
    for (int k = 1; k <= 30; k++) begin
      left_raw  = (k <= 20);
      right_raw = (k >= 10);
      tick();
      check3("left_then_right", k,
             {(k >= 7 && k <= 26), (k >= 28), 1'b0});
    end

    // Hazard overrides LEFT, then falls back through IDLE into LEFT.
    reset_dut();
    for (int k = 1; k <= 30; k++) begin
      left_raw   = 1'b1;
      hazard_raw = (k >= 10 && k <= 19);
      tick();
      if (k < 7)        check3("hazard_override", k, 3'b000);
      else if (k <= 15) check3("hazard_override", k, 3'b100);
      else if (k <= 25) check3("hazard_override", k, 3'b111);
      else if (k == 26) check3("hazard_override", k, 3'b000);
      else              check3("hazard_override", k, 3'b100);
    end
`else
    // Tap mode: first debounced tap latches LEFT, second tap releases it.
    reset_dut();
    for (int k = 1; k <= 22; k++) begin
      left_raw = (k <= 4) || (k >= 11 && k <= 14);
      tick();
      check3("latch_two_taps", k, {(k >= 7 && k <= 16), 2'b00});
    end

    // Tap mode: an opposite tap cancels LEFT back to IDLE.
    reset_dut();
    for (int k = 1; k <= 22; k++) begin
      left_raw  = (k <= 4);
      right_raw = (k >= 11 && k <= 14);
      tick();
      check3("latch_cancel", k, {(k >= 7 && k <= 16), 2'b00});
    end
`endif

    // Reset asserted between edges clears outputs before the next edge.
    reset_dut();
    left_raw = 1'b1;
    repeat (10) tick();
    check3("async_pre", 0, 3'b100);
    #3 reset = 1'b1;
    #1 check3("async_mid_cycle", 0, 3'b000);
    #2 reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) check3("async_recover_edge6", e, 3'b000);
      if (e == 7) check3("async_recover_edge7", e, 3'b100);
    end
    left_raw = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
